// File: rtl/digit_serial_adder_pkg.sv
// Shared types and sizing helpers for the digit-serial adder.
// One 4-bit digit is processed per cycle, LSD first.
package digit_serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DIGIT_W = 4;

  function automatic int ndig_f(input int w);
    return w / DIGIT_W;
  endfunction

  function automatic int cnt_w_f(input int w);
    return (w / DIGIT_W > 1) ? $clog2(w / DIGIT_W) : 1;
  endfunction

endpackage

// File: rtl/digit_serial_adder_cla4_slice.sv
// Combinational 4-bit carry-lookahead adder slice.
// Carries are formed directly from generate/propagate terms.
module cla4_slice (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);

  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] c;

  always_comb begin
    g = x & y;
    p = x ^ y;
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0])
         | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1])
         | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & ci);
    co   = g[3] | (p[3] & g[2])
         | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & ci);
    s = p ^ c;
  end

endmodule

// File: rtl/digit_serial_adder.sv
// Sequential WIDTH-bit adder reusing one CLA slice per digit.
// Valid/ready on both sides; result held until accepted.
module digit_serial_adder
  import digit_serial_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NDIG = ndig_f(WIDTH);
  localparam int CW   = cnt_w_f(WIDTH);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [DIGIT_W-1:0]       dig_s;
  logic                     dig_co;
  logic [WIDTH+DIGIT_W-1:0] sum_cat;

  cla4_slice u_slice (
    .x  (a_sh_q[DIGIT_W-1:0]),
    .y  (b_sh_q[DIGIT_W-1:0]),
    .ci (carry_q),
    .s  (dig_s),
    .co (dig_co)
  );

  // New digit enters at the MSB end; dropping the low digit
  // leaves the accumulated sum right-aligned after NDIG steps.
  assign sum_cat = {dig_s, sum_sh_q};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = cin;
          cnt_d   = '0;
          a_msb_d = a[WIDTH-1];
          b_msb_d = b[WIDTH-1];
          state_d = RUN;
        end
      end
      RUN: begin
        a_sh_d   = a_sh_q >> DIGIT_W;
        b_sh_d   = b_sh_q >> DIGIT_W;
        sum_sh_d = sum_cat[WIDTH+DIGIT_W-1:DIGIT_W];
        carry_d  = dig_co;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(NDIG - 1)) begin
          sum_d   = sum_sh_d;
          cout_d  = dig_co;
          ovf_d   = a_msb_q ^ b_msb_q
                  ^ sum_sh_d[WIDTH-1] ^ dig_co;
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_digit_serial_adder.sv
// Directed and randomized checks for digit_serial_adder, WIDTH=16.
// Inputs driven #1 after posedge; outputs sampled there too.
module tb_digit_serial_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;

  int n_pass = 0;
  int n_tot  = 0;

  digit_serial_adder #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] s;
    logic        co;
    logic        ov;
  } vec_t;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands, wait for accept, count edges to out_valid.
  // wig=1 wiggles inputs during RUN to prove they are ignored.
  task automatic run_op(input logic [15:0] va,
                        input logic [15:0] vb,
                        input logic        vc,
                        input bit          wig,
                        output int         lat);
    int k;
    a = va;
    b = vb;
    cin = vc;
    in_valid = 1'b1;
    k = 0;
    while (!in_ready && k < 20) begin
      tick();
      k++;
    end
    tick();
    lat = 0;
    in_valid = 1'b0;
    while (lat < 20) begin
      if (wig) begin
        in_valid  = 1'($urandom_range(0, 1));
        a         = 16'($urandom);
        b         = 16'($urandom);
        cin       = 1'($urandom_range(0, 1));
        out_ready = 1'($urandom_range(0, 1));
      end
      tick();
      lat++;
      if (out_valid) break;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    if (!out_valid)
      chk("out_valid_timeout", 32'(out_valid), 32'd1);
  endtask

  task automatic finish_op();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  vec_t vt[6];
  int   lat;
  int   seen;
  logic [16:0] ref_full;
  logic        ref_ov;

  initial begin
    vt[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
    vt[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vt[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vt[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vt[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vt[5] = '{16'h0F0F, 16'h00F1, 1'b1, 16'h1001, 1'b0, 1'b0};

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    cin = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout_ovf", {30'd0, cout, ovf}, 32'd0);

    // out_ready in IDLE must not do anything
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("idle_out_ready", {30'd0, in_ready, out_valid},
        32'b10);

    for (int i = 0; i < 6; i++) begin
      run_op(vt[i].a, vt[i].b, vt[i].cin, 1'b0, lat);
      chk($sformatf("v%0d_lat", i), 32'(lat), 32'd4);
      chk($sformatf("v%0d_sum", i), 32'(sum), 32'(vt[i].s));
      chk($sformatf("v%0d_cout", i), 32'(cout),
          32'(vt[i].co));
      chk($sformatf("v%0d_ovf", i), 32'(ovf), 32'(vt[i].ov));
      finish_op();
      chk($sformatf("v%0d_idle", i),
          {30'd0, in_ready, out_valid}, 32'b10);
    end

    // Held result under back-pressure
    run_op(16'h0000, 16'h0000, 1'b1, 1'b0, lat);
    chk("stall_lat", 32'(lat), 32'd4);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("stall%0d", i),
          {13'd0, out_valid, in_ready, cout, sum},
          {13'd0, 1'b1, 1'b0, 1'b0, 16'h0001});
    end
    finish_op();
    chk("stall_release", {30'd0, in_ready, out_valid},
        32'b10);
    chk("stall_sum_kept", 32'(sum), 32'h0001);

    // Reset during the second RUN cycle aborts the op
    a = 16'hABCD;
    b = 16'h1111;
    cin = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_sum", 32'(sum), 32'd0);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) seen++;
      tick();
    end
    chk("abort_no_valid", 32'(seen), 32'd0);
    run_op(16'h0F0F, 16'h00F1, 1'b0, 1'b0, lat);
    chk("abort_next_sum", 32'(sum), 32'h1000);
    chk("abort_next_cout", 32'(cout), 32'd0);
    finish_op();

    // Operands captured at accept; inputs wiggle during RUN
    for (int i = 0; i < 1000; i++) begin
      logic [15:0] ra;
      logic [15:0] rb;
      logic        rc;
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom_range(0, 1));
      ref_full = {1'b0, ra} + {1'b0, rb} + {16'd0, rc};
      ref_ov = (ra[15] == rb[15]) &&
               (ref_full[15] != ra[15]);
      run_op(ra, rb, rc, i < 20, lat);
      chk($sformatf("rnd%0d", i),
          {13'd0, 1'b0, ovf, cout, sum},
          {13'd0, 1'b0, ref_ov, ref_full[16], ref_full[15:0]});
      finish_op();
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/digit_serial_adder.md
Name: digit_serial_adder

Overview:
- Sequential N-bit adder that reuses one 4-bit carry-lookahead slice over multiple cycles.
- Processes one 4-bit digit per cycle, least-significant digit first, and holds the inter-digit carry in a register.
- Sits between an operand source and a result consumer, with a valid/ready handshake on each side.
- Trades latency for area against a full-width CLA.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4.
- NDIG, WIDTH/4 (localparam), number of digit cycles per operation.

Ports:
- clk  input  1  single clock, rising-edge.
- rst  input  1  reset; one clock, reset is synchronous and active-high.
- in_valid  input  1  operand bundle valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry into bit 0.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  a+b+cin, modulo 2^WIDTH.
- cout  output  1  carry out of bit WIDTH-1.
- ovf  output  1  two's-complement signed overflow.

Behaviour:
- States: IDLE, RUN, DONE; state register is binary-encoded.
- Reset (rst=1 at a rising edge):
  - state goes to IDLE.
  - Internal registers (digit counter, carry, shift registers) clear to 0.
  - Outputs: sum=0, cout=0, ovf=0, out_valid=0, in_ready=1 from the cycle after the reset edge.
- IDLE:
  - in_ready=1, out_valid=0.
  - If in_valid=1 at an edge: load a and b into shift registers, load cin into the carry register, clear the digit counter, go to RUN.
  - If in_valid=0: remain in IDLE.
- RUN (in_ready=0, out_valid=0), each cycle:
  - The 4-bit slice adds a_sh[3:0] + b_sh[3:0] + carry.
  - The slice sum digit shifts into sum_sh from the MSB end.
  - a_sh and b_sh shift right by 4; the carry register takes the slice carry-out; the counter increments.
  - The edge with counter==NDIG-1 performs the final digit, captures cout, computes ovf, and goes to DONE.
- Signed overflow rule: ovf = c_in_msb XOR cout, where c_in_msb = a[WIDTH-1] ^ b[WIDTH-1] ^ sum[WIDTH-1].
  - The MSBs of a and b are retained in dedicated registers at accept, because the shift registers lose them.
- DONE:
  - out_valid=1; sum, cout and ovf are held stable while out_valid=1 and out_ready=0.
  - If out_ready=1 at an edge: go to IDLE.
  - in_ready=0 throughout DONE; there is no same-cycle turnaround.
- Latency:
  - Accept edge E0; result registered at edge E_NDIG (edges E1..E_NDIG are the RUN edges); out_valid high from edge E_NDIG.
  - WIDTH=16 gives out_valid 4 cycles after acceptance.
  - Minimum issue interval is NDIG+2 cycles.
- Boundaries and stalls:
  - WIDTH=4 (NDIG=1): exactly one RUN cycle.
  - in_valid during RUN or DONE is ignored; the source must hold its bundle until in_ready=1.
  - Operand inputs are sampled only at the accept edge; changes afterwards have no effect.
  - out_ready=1 outside DONE has no effect.
  - Reset asserted in RUN or DONE aborts the operation and discards the partial result; no out_valid pulse follows.
- Outputs after the handshake: sum, cout and ovf keep their last values in IDLE and RUN until the next result is registered. Only out_valid qualifies them.

Decomposition:
- Shared package:
  - state enum (IDLE, RUN, DONE).
  - DIGIT_W=4 constant.
  - localparam helper for NDIG and the counter width $clog2(NDIG) (min 1).
- Sub-module cla4_slice: pure combinational 4-bit carry-lookahead adder.
  - Inputs: x[3:0], y[3:0], ci.
  - Outputs: s[3:0], co.
  - Uses generate/propagate terms; instantiated once.
- Top module: FSM, counter, shift registers, carry and MSB registers.

Test Plan:
- WIDTH=16: a=0x1234, b=0x4321, cin=0 -> sum=0x5555, cout=0, ovf=0; out_valid exactly 4 cycles after the accept edge.
- a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0; checks carry ripple across all 4 digit cycles.
- a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1; a=0x8000, b=0x8000 -> sum=0x0000, cout=1, ovf=1.
- a=0, b=0, cin=1 -> sum=0x0001.
  - Then hold out_ready=0 for 5 cycles: sum stable, out_valid=1, in_ready=0.
  - Then raise out_ready: IDLE and in_ready=1 on the next cycle.
- Pulse rst during the 2nd RUN cycle of a=0xABCD, b=0x1111:
  - No out_valid pulse.
  - in_ready=1 after the reset edge.
  - Next op a=0x0F0F, b=0x00F1 -> sum=0x1000, cout=0.
- Toggle in_valid and a during RUN: the result still matches the operands captured at accept; a random 1000-op run compared against a+b+cin passes.
